muldiv_seq: RTL and testbench

- Sequencer for the shared arithmetic resource: accepts one ADD/SUB/MUL/DIV request at a time over a valid/ready handshake.
- Runs MUL as iterative shift-add and DIV as iterative 64/32 restoring division, one bit per cycle.
- Returns the result over a valid/ready response channel.
- Sits between instruction issue and writeback so a single iterative engine replaces the combinational mul/div arrays.

---
 rtl/muldiv_seq_if.sv | 36 +++
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response channel between instruction issue and the
// shared iterative arithmetic engine.
//   req_valid/req_ready : request handshake (requester -> engine)
//   req_op              : 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   req_a               : 2*WIDTH dividend for DIV, low WIDTH bits otherwise
//   req_b               : second operand / divisor
//   resp_valid/ready    : response handshake (engine -> consumer)
//   resp_lo/resp_hi     : result halves
//   resp_dz/resp_ovf    : divide-by-zero / quotient-overflow flags
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_op;
   logic [2*WIDTH-1:0]   req_a;
   logic [WIDTH-1:0]     req_b;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [WIDTH-1:0]     resp_lo;
   logic [WIDTH-1:0]     resp_hi;
   logic                 resp_dz;
   logic                 resp_ovf;

   // Requester side: issues operations and consumes results.
   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_lo, resp_hi, resp_dz, resp_ovf
   );

   // Engine side.
   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_lo, resp_hi, resp_dz, resp_ovf
   );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: one-at-a-time sequencer for ADD/SUB/MUL/DIV. ADD/SUB and the
// DIV corner cases (divide by zero, quotient overflow) finish on the accept
// edge; MUL (shift-add) and DIV (64/32 restoring) iterate one bit per clock.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : muldiv_seq_if slave modport (request and response channels)
//   busy : high whenever the engine is not idle
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_seq_if.slave    bus,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0]       OP_ADD = 2'b00;
   localparam logic [1:0]       OP_SUB = 2'b01;
   localparam logic [1:0]       OP_MUL = 2'b10;
   localparam logic [1:0]       OP_DIV = 2'b11;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state_r, state_nx_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
   logic               is_div_r, is_div_nx_s;
   logic [WIDTH-1:0]   b_r, b_nx_s;
   // hi_r carries one extra bit so the DIV partial remainder fits after its shift.
   logic [WIDTH:0]     hi_r, hi_nx_s;
   logic [WIDTH-1:0]   lo_r, lo_nx_s;
   logic               dz_r, dz_nx_s;
   logic               ovf_r, ovf_nx_s;
   logic               valid_r;
   logic               busy_r;

   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_sh_s;
   logic [WIDTH-1:0]   div_qsh_s;
   logic [WIDTH:0]     div_rem_s;
   logic [WIDTH-1:0]   div_q_s;
   logic [WIDTH-1:0]   a_lo_s;
   logic [WIDTH-1:0]   a_hi_s;

   assign a_lo_s = bus.req_a[WIDTH-1:0];
   assign a_hi_s = bus.req_a[2*WIDTH-1:WIDTH];

   // Accept only while idle and not being reset.
   assign bus.req_ready  = (state_r == IDLE) && !rst;
   assign bus.resp_valid = valid_r;
   assign bus.resp_lo    = lo_r;
   assign bus.resp_hi    = hi_r[WIDTH-1:0];
   assign bus.resp_dz    = dz_r;
   assign bus.resp_ovf   = ovf_r;
   assign busy           = busy_r;

   // Single-cycle add/sub and one MUL/DIV step computed from the held state.
   always_comb begin
      add_s     = {1'b0, a_lo_s} + {1'b0, bus.req_b};
      sub_s     = {1'b0, a_lo_s} - {1'b0, bus.req_b};
      // MUL: add b when the current multiplier bit is set; carry lands in bit WIDTH.
      if (lo_r[0]) begin
         mul_sum_s = hi_r + {1'b0, b_r};
      end else begin
         mul_sum_s = hi_r;
      end
      // DIV: shift {R, Q} left, then restore-style compare and subtract.
      div_sh_s  = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
      div_qsh_s = {lo_r[WIDTH-2:0], 1'b0};
      if (div_sh_s >= {1'b0, b_r}) begin
         div_rem_s = div_sh_s - {1'b0, b_r};
         div_q_s   = div_qsh_s | {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         div_rem_s = div_sh_s;
         div_q_s   = div_qsh_s;
      end
   end

   // Next-state and datapath update for the IDLE/CALC/DONE controller.
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      is_div_nx_s = is_div_r;
      b_nx_s      = b_r;
      hi_nx_s     = hi_r;
      lo_nx_s     = lo_r;
      dz_nx_s     = dz_r;
      ovf_nx_s    = ovf_r;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               dz_nx_s     = 1'b0;
               ovf_nx_s    = 1'b0;
               cnt_nx_s    = {CNT_W{1'b0}};
               b_nx_s      = bus.req_b;
               is_div_nx_s = 1'b0;
               case (bus.req_op)
                  OP_ADD: begin
                     hi_nx_s    = {{WIDTH{1'b0}}, add_s[WIDTH]};
                     lo_nx_s    = add_s[WIDTH-1:0];
                     state_nx_s = DONE;
                  end
                  OP_SUB: begin
                     hi_nx_s    = {{WIDTH{1'b0}}, sub_s[WIDTH]};
                     lo_nx_s    = sub_s[WIDTH-1:0];
                     state_nx_s = DONE;
                  end
                  OP_MUL: begin
                     hi_nx_s    = {(WIDTH+1){1'b0}};
                     lo_nx_s    = a_lo_s;
                     state_nx_s = CALC;
                  end
                  OP_DIV: begin
                     if (bus.req_b == {WIDTH{1'b0}}) begin
                        hi_nx_s    = {1'b0, a_lo_s};
                        lo_nx_s    = {WIDTH{1'b1}};
                        dz_nx_s    = 1'b1;
                        state_nx_s = DONE;
                     end else if (a_hi_s >= bus.req_b) begin
                        hi_nx_s    = {1'b0, a_lo_s};
                        lo_nx_s    = {WIDTH{1'b1}};
                        ovf_nx_s   = 1'b1;
                        state_nx_s = DONE;
                     end else begin
                        hi_nx_s     = {1'b0, a_hi_s};
                        lo_nx_s     = a_lo_s;
                        is_div_nx_s = 1'b1;
                        state_nx_s  = CALC;
                     end
                  end
                  default: begin
                     state_nx_s = IDLE;
                  end
               endcase
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            if (is_div_r) begin
               hi_nx_s = div_rem_s;
               lo_nx_s = div_q_s;
            end else begin
               hi_nx_s = {1'b0, mul_sum_s[WIDTH:1]};
               lo_nx_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
            end
            cnt_nx_s = cnt_r + CNT_W'(1);
            if (cnt_r == LAST_ITER) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = CALC;
            end
         end
         DONE: begin
            if (bus.resp_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         is_div_r <= 1'b0;
         b_r      <= {WIDTH{1'b0}};
         hi_r     <= {(WIDTH+1){1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         dz_r     <= 1'b0;
         ovf_r    <= 1'b0;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         cnt_r    <= cnt_nx_s;
         is_div_r <= is_div_nx_s;
         b_r      <= b_nx_s;
         hi_r     <= hi_nx_s;
         lo_r     <= lo_nx_s;
         dz_r     <= dz_nx_s;
         ovf_r    <= ovf_nx_s;
         valid_r  <= (state_nx_s == DONE);
         busy_r   <= (state_nx_s != IDLE);
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed bench for muldiv_seq, checked against
// an arithmetic reference model.
module tb_muldiv_seq;

   logic clk;
   logic rst;
   logic busy;
   int   checks;
   int   errors;

   muldiv_seq_if #(.WIDTH(32)) bus ();

   muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain arithmetic on the operation's definition.
   task automatic ref_model(input logic [1:0] op, input logic [63:0] a, input logic [31:0] b,
                            output logic [31:0] lo, output logic [31:0] hi,
                            output logic dz, output logic ovf, output int lat);
      logic [63:0] t;
      dz = 1'b0; ovf = 1'b0; lat = 1;
      case (op)
         2'b00: begin t = {32'd0, a[31:0]} + {32'd0, b}; lo = t[31:0]; hi = {31'd0, t[32]}; end
         2'b01: begin lo = a[31:0] - b; hi = (a[31:0] < b) ? 32'd1 : 32'd0; end
         2'b10: begin t = {32'd0, a[31:0]} * {32'd0, b}; lo = t[31:0]; hi = t[63:32]; lat = 33; end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFFFFFF; hi = a[31:0]; dz = 1'b1;
            end else if (a[63:32] >= b) begin
               lo = 32'hFFFFFFFF; hi = a[31:0]; ovf = 1'b1;
            end else begin
               t = a / {32'd0, b}; lo = t[31:0];
               t = a % {32'd0, b}; hi = t[31:0];
               lat = 33;
            end
         end
      endcase
   endtask

   // Driver: issue one op (called at a negedge with the engine idle), optionally
   // stall the response and toggle request noise while busy; report observations.
   task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [31:0] b,
                        input int stall, input bit noise,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output logic dz, output logic ovf, output int lat,
                        output bit timeout, output bit stable, output bit held_off,
                        output logic after_valid, output logic after_ready);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
      bus.resp_ready = 1'b0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      timeout = 1'b0; stable = 1'b1; held_off = 1'b1;
      while (!bus.resp_valid && lat < 100) begin
         if (noise) begin
            bus.req_valid = 1'b1; bus.req_op = 2'($urandom);
            bus.req_a = {$urandom, $urandom}; bus.req_b = $urandom;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      lo = bus.resp_lo; hi = bus.resp_hi; dz = bus.resp_dz; ovf = bus.resp_ovf;
      if (!bus.resp_valid) begin
         timeout = 1'b1; after_valid = 1'b0; after_ready = 1'b1;
         return;
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.resp_valid || bus.resp_lo !== lo || bus.resp_hi !== hi ||
             bus.resp_dz !== dz || bus.resp_ovf !== ovf) stable = 1'b0;
         if (bus.req_ready !== 1'b0) held_off = 1'b0;
      end
      if (bus.req_ready !== 1'b0) held_off = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      after_valid = bus.resp_valid;
      after_ready = bus.req_ready;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = 64'd0; bus.req_b = 32'd0;
      bus.resp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", bus.req_ready); end
      checks++;
      if ({busy, bus.resp_valid, bus.resp_dz, bus.resp_ovf} !== 4'b0000 || bus.resp_lo !== 32'd0 || bus.resp_hi !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%0b v=%0b dz=%0b ovf=%0b lo=%h hi=%h want all 0",
                  busy, bus.resp_valid, bus.resp_dz, bus.resp_ovf, bus.resp_lo, bus.resp_hi);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", bus.req_ready); end
   endtask

   task automatic test_div_directed();
      logic [31:0] lo, hi; logic dz, ovf, av, ar; int lat; bit to, st, ho;
      do_op(2'b11, 64'd5106514152, 32'd5115, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || lat != 33) begin errors++; $display("FAIL div_latency got %0d (timeout=%0b) want 33", lat, to); end
      checks++;
      if (lo !== 32'd998340 || hi !== 32'd5052 || dz !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL div_result got lo=%0d hi=%0d dz=%0b ovf=%0b want 998340 5052 0 0", lo, hi, dz, ovf);
      end
   endtask

   task automatic test_mul_stall();
      logic [31:0] lo, hi; logic dz, ovf, av, ar; int lat; bit to, st, ho;
      do_op(2'b10, 64'h0000_0000_FFFF_FFFF, 32'hFFFFFFFF, 5, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || {hi, lo} !== 64'hFFFFFFFE_00000001 || lat != 33) begin
         errors++; $display("FAIL mul_max got %h_%h lat=%0d want fffffffe_00000001 lat=33", hi, lo, lat);
      end
      checks++;
      if (!st) begin errors++; $display("FAIL mul_stall_stable got unstable want stable"); end
      checks++;
      if (!ho) begin errors++; $display("FAIL mul_stall_req_ready got 1 during DONE want 0"); end
      checks++;
      if (av !== 1'b0 || ar !== 1'b1) begin
         errors++; $display("FAIL mul_release got valid=%0b ready=%0b want 0 1", av, ar);
      end
   endtask

   task automatic test_add_sub();
      logic [31:0] lo, hi; logic dz, ovf, av, ar; int lat; bit to, st, ho;
      do_op(2'b00, 64'h0000_0000_FFFF_FFFF, 32'd1, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || lat != 1 || lo !== 32'd0 || hi !== 32'd1 || dz !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL add_carry got lo=%h hi=%h lat=%0d want 0 1 lat=1", lo, hi, lat);
      end
      do_op(2'b01, 64'd0, 32'd1, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || lat != 1 || lo !== 32'hFFFFFFFF || hi !== 32'd1) begin
         errors++; $display("FAIL sub_borrow got lo=%h hi=%h lat=%0d want ffffffff 1 lat=1", lo, hi, lat);
      end
   endtask

   task automatic test_div_special();
      logic [31:0] lo, hi; logic dz, ovf, av, ar; int lat; bit to, st, ho;
      do_op(2'b11, 64'h5, 32'd0, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || lat != 1 || dz !== 1'b1 || ovf !== 1'b0 || lo !== 32'hFFFFFFFF || hi !== 32'd5) begin
         errors++; $display("FAIL div_zero got dz=%0b ovf=%0b lo=%h hi=%h lat=%0d want 1 0 ffffffff 5 lat=1", dz, ovf, lo, hi, lat);
      end
      do_op(2'b11, 64'h0000_0010_0000_0000, 32'd16, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || lat != 1 || ovf !== 1'b1 || dz !== 1'b0 || lo !== 32'hFFFFFFFF || hi !== 32'd0) begin
         errors++; $display("FAIL div_ovf got ovf=%0b dz=%0b lo=%h hi=%h lat=%0d want 1 0 ffffffff 0 lat=1", ovf, dz, lo, hi, lat);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] lo, hi; logic dz, ovf, av, ar; int lat; bit to, st, ho; bit seen;
      bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_a = 64'd12345; bus.req_b = 32'd678;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL abort_idle got busy=%0b ready=%0b want 0 1", busy, bus.req_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_no_resp got resp_valid=1 want 0"); end
      do_op(2'b10, 64'd3, 32'd7, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
      checks++;
      if (to || lat != 33 || lo !== 32'd21 || hi !== 32'd0) begin
         errors++; $display("FAIL abort_next_mul got lo=%0d hi=%0d lat=%0d want 21 0 lat=33", lo, hi, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] lo, hi, elo, ehi; logic dz, ovf, edz, eovf, av, ar; int lat, elat; bit to, st, ho;
      logic [1:0] op; logic [63:0] a; logic [31:0] b; int k;
      for (int n = 0; n < 24; n++) begin
         op = 2'($urandom); a = {$urandom, $urandom}; b = $urandom;
         if (op == 2'b11) begin
            k = $urandom_range(0, 5);
            if (k == 0) b = 32'd0;
            else if (k == 1) a[63:32] = b;
            else begin
               if (b == 32'd0) b = 32'd1;
               a[63:32] = $urandom % b;
            end
         end
         ref_model(op, a, b, elo, ehi, edz, eovf, elat);
         do_op(op, a, b, $urandom_range(0, 2), 1'b1, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
         checks++;
         if (to || lo !== elo || hi !== ehi || dz !== edz || ovf !== eovf || lat != elat) begin
            errors++;
            $display("FAIL random_%0d op=%0d a=%h b=%h got lo=%h hi=%h dz=%0b ovf=%0b lat=%0d want lo=%h hi=%h dz=%0b ovf=%0b lat=%0d",
                     n, op, a, b, lo, hi, dz, ovf, lat, elo, ehi, edz, eovf, elat);
         end
         checks++;
         if (!st || !ho || av !== 1'b0 || ar !== 1'b1) begin
            errors++; $display("FAIL random_hs_%0d got stable=%0b held=%0b v=%0b r=%0b want 1 1 0 1", n, st, ho, av, ar);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] lo, hi, elo, ehi; logic dz, ovf, edz, eovf, av, ar; int lat, elat; bit to, st, ho;
      logic [63:0] a; logic [31:0] b;
      // Flags from a DIV-by-zero must not leak into the following ops.
      for (int n = 0; n < 4; n++) begin
         a = {32'd0, $urandom}; b = (n % 2 == 0) ? 32'd0 : $urandom;
         ref_model((n % 2 == 0) ? 2'b11 : 2'b00, a, b, elo, ehi, edz, eovf, elat);
         do_op((n % 2 == 0) ? 2'b11 : 2'b00, a, b, 0, 1'b0, lo, hi, dz, ovf, lat, to, st, ho, av, ar);
         checks++;
         if (to || lo !== elo || hi !== ehi || dz !== edz || ovf !== eovf || lat != elat) begin
            errors++; $display("FAIL b2b_%0d got lo=%h hi=%h dz=%0b ovf=%0b want lo=%h hi=%h dz=%0b ovf=%0b",
                               n, lo, hi, dz, ovf, elo, ehi, edz, eovf);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_div_directed();
      test_mul_stall();
      test_add_sub();
      test_div_special();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
